// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the framebuffer bus arbiter.
package fb_arb_pkg;

  // Encoding matches the gnt output: 00 none, 01 video, 10 writer.
  typedef enum logic [1:0] {
    Idle   = 2'b00,
    GntVid = 2'b01,
    GntWr  = 2'b10
  } fb_gnt_t;

  localparam int unsigned AckCntW    = 8;
  localparam int unsigned DefWrQuota = 16;
  localparam int unsigned DefTimeout = 64;

endpackage

// File: rtl/fb_arb_watchdog.sv
// Stall watchdog: pulses timeout for one cycle after TIMEOUT consecutive unacked strobe cycles.
module fb_arb_watchdog
  import fb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  input  logic err,
  input  logic clear,
  output logic timeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stall;

  always_comb begin
    stall   = stb & ~ack & ~err;
    timeout = stall && (cnt_q == CntW'(TIMEOUT - 1));
    cnt_d   = cnt_q + CntW'(1);
    if (clear || !stall || timeout) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Two-master Wishbone arbiter: video (m0) fixed priority, writer (m1) bounded by an ack quota.
// Optional stall watchdog enabled by defining FB_ARB_WATCHDOG_EN.
module fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WR_QUOTA = DefWrQuota,
  parameter int unsigned TIMEOUT  = DefTimeout,
  localparam int unsigned SEL_W   = DATA_W / 8
) (
  input  logic              pixel_clk,
  input  logic              pixel_rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_dat_w,
  output logic [DATA_W-1:0] m0_dat_r,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_dat_w,
  output logic [DATA_W-1:0] m1_dat_r,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_dat_w,
  input  logic [DATA_W-1:0] s_dat_r,
  input  logic              s_ack,
  input  logic              s_err,
  output logic [1:0]        gnt
);

  localparam logic [AckCntW-1:0] Quota = AckCntW'(WR_QUOTA);

  fb_gnt_t             state_q, state_d;
  logic [AckCntW-1:0]  ack_cnt_q, ack_cnt_d;
  logic                wd_timeout;
  logic                done;

`ifdef FB_ARB_WATCHDOG_EN
  fb_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (pixel_clk),
    .rst_n  (pixel_rst_n),
    .stb    (s_stb),
    .ack    (s_ack),
    .err    (s_err),
    .clear  (state_d != state_q),
    .timeout(wd_timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_timeout     = 1'b0;
`endif

  // A watchdog pulse completes the stalled transfer just like an ack or err.
  assign done = s_ack | s_err | wd_timeout;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle: begin
        if (m0_cyc) begin
          state_d = GntVid;
        end else if (m1_cyc) begin
          state_d = GntWr;
        end
      end
      GntVid: begin
        if (!m0_cyc) begin
          state_d = m1_cyc ? GntWr : Idle;
        end
      end
      GntWr: begin
        if (!m1_cyc) begin
          state_d = m0_cyc ? GntVid : Idle;
        end else if (done && m0_cyc && (ack_cnt_q >= Quota - AckCntW'(1))) begin
          state_d = GntVid;
        end
      end
      default: state_d = Idle;
    endcase
    if (wd_timeout) begin
      state_d = Idle;
    end
  end

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    if ((state_d == GntWr) && (state_q != GntWr)) begin
      ack_cnt_d = '0;
    end else if ((state_q == GntWr) && done && (ack_cnt_q < Quota)) begin
      ack_cnt_d = ack_cnt_q + AckCntW'(1);
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state_q   <= Idle;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    unique case (state_q)
      GntVid: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_sel   = m0_sel;
        s_dat_w = m0_dat_w;
        m0_ack  = s_ack;
        m0_err  = s_err | wd_timeout;
      end
      GntWr: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_sel   = m1_sel;
        s_dat_w = m1_dat_w;
        m1_ack  = s_ack;
        m1_err  = s_err | wd_timeout;
      end
      default: ;
    endcase
  end

  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;
  assign gnt      = state_q;

endmodule
